// File: rtl/counter_tb_dut.sv
// counter_tb_dut: loadable, enabled binary up-counter with a synchronous parallel load.
// Priority per clock edge: load, then increment (modulo 2**WIDTH), then hold.
// rst_n is asynchronous and active-HIGH; the historical name is kept for the codebase.
// Optional: define COUNTER_TB_SVA_EN to compile in the behavioural assertions and the
// wrap cover point. With the macro undefined the functional logic is unchanged.
module counter_tb_dut #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_enb,
  input  logic             count_enb,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next-state select: load beats increment, increment beats hold.
  always_comb begin
    cnt_d = cnt_q;
    if (ld_enb) begin
      cnt_d = data_in;
    end else if (count_enb) begin
      // Natural truncation to WIDTH bits gives the wrap to zero.
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // State register; reset is asynchronous and takes priority over any pending update.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_out = cnt_q;

`ifdef COUNTER_TB_SVA_EN
  localparam logic [WIDTH-1:0] AllOnes = '1;

  // A load is visible one edge later.
  a_load: assert property (@(posedge clk) disable iff (rst_n)
    ld_enb |=> count_out == $past(data_in));

  // An increment is visible one edge later, modulo 2**WIDTH.
  a_incr: assert property (@(posedge clk) disable iff (rst_n)
    (!ld_enb && count_enb) |=> count_out == WIDTH'($past(count_out) + 1'b1));

  // With both controls low the value holds.
  a_hold: assert property (@(posedge clk) disable iff (rst_n)
    (!ld_enb && !count_enb) |=> $stable(count_out));

  // The registered output is never unknown.
  a_no_x: assert property (@(posedge clk) disable iff (rst_n)
    !$isunknown(count_out));

  // The all-ones to zero wrap is exercised.
  c_wrap: cover property (@(posedge clk) disable iff (rst_n)
    (count_out == AllOnes && !ld_enb && count_enb) ##1 (count_out == '0));
`endif

endmodule

// File: tb/tb_counter_tb_dut.sv
// tb_counter_tb_dut: directed self-checking bench for counter_tb_dut (WIDTH=8, RESET_VAL=0).
// Controls change on negedge; outputs are sampled 1 time unit after posedge or mid-cycle.
module tb_counter_tb_dut;

  logic       clk;
  logic       rst_n;
  logic       ld_enb;
  logic       count_enb;
  logic [7:0] data_in;
  logic [7:0] count_out;

  int n_checks = 0;
  int n_pass   = 0;

  counter_tb_dut #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_enb    (ld_enb),
    .count_enb (count_enb),
    .data_in   (data_in),
    .count_out (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: count_out=%h expected=%h at t=%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic ld, input logic ce, input logic [7:0] d);
    @(negedge clk);
    ld_enb    = ld;
    count_enb = ce;
    data_in   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    ld_enb    = 1'b0;
    count_enb = 1'b0;
    data_in   = 8'h00;

    // Reset held two cycles, then released.
    #1;
    check("reset_async", count_out, 8'h00);
    tick();
    check("reset_cyc1", count_out, 8'h00);
    tick();
    check("reset_cyc2", count_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    check("post_release", count_out, 8'h00);

    // Load wins over count enable.
    drive(1'b1, 1'b1, 8'hF0);
    tick();
    check("load_priority", count_out, 8'hF0);

    // Count F1..FF, then wrap to 00.
    drive(1'b0, 1'b1, 8'h55);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("count_%0d", i), count_out, 8'(8'hF0 + i));
    end
    tick();
    check("wrap", count_out, 8'h00);

    // Hold at 42 for five cycles while data_in wiggles.
    drive(1'b1, 1'b0, 8'h42);
    tick();
    check("load_42", count_out, 8'h42);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'(8'h10 + i));
      tick();
      check($sformatf("hold_%0d", i), count_out, 8'h42);
    end

    // Reach 37 by load 30 plus seven increments, then reset mid-cycle.
    drive(1'b1, 1'b0, 8'h30);
    tick();
    check("load_30", count_out, 8'h30);
    drive(1'b0, 1'b1, 8'h00);
    repeat (7) tick();
    check("count_37", count_out, 8'h37);
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_midcycle", count_out, 8'h00);
    tick();
    check("reset_hold_edge", count_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    check("resume_01", count_out, 8'h01);
    tick();
    check("resume_02", count_out, 8'h02);

    // Load all-ones, then increment wraps to zero.
    drive(1'b1, 1'b0, 8'hFF);
    tick();
    check("load_ff", count_out, 8'hFF);
    drive(1'b0, 1'b1, 8'h00);
    tick();
    check("load_ff_wrap", count_out, 8'h00);
    tick();
    check("after_wrap_01", count_out, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
